mem_arbiter: RTL and testbench

- Shares the single-port `memory` block between two requesters: port 0 (instruction fetch) and port 1 (load/store unit).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- Round-robin arbitration; one memory transaction in flight at a time.
- Sits between the core front-end/LSU and `memory`; drives `memory`'s addr/data_in/write_enable and samples its data_out.

---
 rtl/mem_arb_pkg.sv | 31 +++
 rtl/mem_arbiter_rr_picker.sv | 35 +++
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types, constants and helpers for the two-port
//               memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int NUM_REQ_MAX        = 2;
    localparam int c_REQ_DATA_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [c_REQ_DATA_WIDTH-1:0] addr;
        logic [c_REQ_DATA_WIDTH-1:0] wdata;
        logic                        we;
    } req_t;

    // Saturating increment for the performance counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational 2-way round-robin choice; the port after
//               last_grant wins if valid, otherwise the other port.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import mem_arb_pkg::*;
(
    input  logic [NUM_REQ_MAX-1:0] req_valid,
    input  logic                   last_grant,
    output logic [NUM_REQ_MAX-1:0] grant,
    output logic                   grant_valid
);

    logic w_pref;
    logic w_other;

    assign w_pref  = ~last_grant;
    assign w_other = last_grant;

    always_comb begin
        grant = '0;
        if (req_valid[w_pref]) begin
            grant[w_pref] = 1'b1;
        end else if (req_valid[w_other]) begin
            grant[w_other] = 1'b1;
        end
    end

    assign grant_valid = |req_valid;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter sharing one single-port memory between
//               two valid/ready requesters, one transaction in flight.
//               Define MEM_ARB_PERF_EN to add grant/conflict counters.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]                 req_we,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    input  logic [NUM_REQ-1:0]                 rsp_ready,
    output logic [DATA_WIDTH-1:0]              rsp_rdata,
    output logic [DATA_WIDTH-1:0]              mem_addr,
    output logic [DATA_WIDTH-1:0]              mem_data_in,
    output logic                               mem_write_enable,
    input  logic [DATA_WIDTH-1:0]              mem_data_out
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]                        perf_grant0,
    output logic [31:0]                        perf_grant1,
    output logic [31:0]                        perf_conflict
`endif
);

    generate
        if (NUM_REQ != NUM_REQ_MAX) begin : g_num_req_check
            $error("mem_arbiter: NUM_REQ must be %0d", NUM_REQ_MAX);
        end
        if (DATA_WIDTH < 1 || DATA_WIDTH > c_REQ_DATA_WIDTH) begin : g_width_check
            $error("mem_arbiter: DATA_WIDTH must be 1..%0d", c_REQ_DATA_WIDTH);
        end
    endgenerate

    arb_state_t              r_state;
    arb_state_t              w_state_nxt;
    req_t                    r_req;
    logic                    r_last_grant;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic [NUM_REQ_MAX-1:0]  w_grant;
    logic                    w_grant_valid;
    logic                    w_win_idx;
    logic                    w_handshake;

    rr_picker u_rr_picker (
        .req_valid   (req_valid),
        .last_grant  (r_last_grant),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    assign w_win_idx = w_grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_handshake      = 1'b0;
        req_ready        = '0;
        rsp_valid        = '0;
        mem_write_enable = 1'b0;
        case (r_state)
            IDLE: begin
                // Qualified by rst_n so req_ready stays low while reset is held.
                req_ready   = rst_n ? w_grant : '0;
                w_handshake = w_grant_valid;
                if (w_grant_valid) begin
                    w_state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                mem_write_enable = r_req.we;
                w_state_nxt      = RESP;
            end
            RESP: begin
                rsp_valid[r_last_grant] = 1'b1;
                if (rsp_ready[r_last_grant]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // The latches only change on a grant, so mem_addr/mem_data_in naturally
    // hold their last value outside ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req        <= '0;
            r_last_grant <= 1'b1;
            r_rsp_rdata  <= '0;
        end else begin
            if (w_handshake) begin
                r_req.addr   <= c_REQ_DATA_WIDTH'(req_addr[w_win_idx]);
                r_req.wdata  <= c_REQ_DATA_WIDTH'(req_wdata[w_win_idx]);
                r_req.we     <= req_we[w_win_idx];
                r_last_grant <= w_win_idx;
            end
            if (r_state == ACCESS) begin
                r_rsp_rdata <= r_req.we ? '0 : mem_data_out;
            end
        end
    end

    assign rsp_rdata   = r_rsp_rdata;
    assign mem_addr    = r_req.addr[DATA_WIDTH-1:0];
    assign mem_data_in = r_req.wdata[DATA_WIDTH-1:0];

`ifdef MEM_ARB_PERF_EN
    logic [31:0] r_perf_grant0;
    logic [31:0] r_perf_grant1;
    logic [31:0] r_perf_conflict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_grant0   <= '0;
            r_perf_grant1   <= '0;
            r_perf_conflict <= '0;
        end else if (w_handshake) begin
            if (w_win_idx) begin
                r_perf_grant1 <= sat_inc32(r_perf_grant1);
            end else begin
                r_perf_grant0 <= sat_inc32(r_perf_grant0);
            end
            if (&req_valid) begin
                r_perf_conflict <= sat_inc32(r_perf_conflict);
            end
        end
    end

    assign perf_grant0   = r_perf_grant0;
    assign perf_grant1   = r_perf_grant1;
    assign perf_conflict = r_perf_conflict;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a memory model and
//               a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_wdata;
    logic [1:0]        req_we;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [31:0]       rsp_rdata;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_data_in;
    logic              mem_write_enable;
    logic [31:0]       mem_data_out;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_grant0;
    logic [31:0]       perf_grant1;
    logic [31:0]       perf_conflict;
`endif

    int errors;
    int checks;
    int we_cnt;
    int model_last;

    logic [31:0] mem_array [0:63] = '{default: '0};
    logic [31:0] ref_mem   [0:63] = '{default: '0};

    mem_arbiter #(.DATA_WIDTH(32), .NUM_REQ(2)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_we           (req_we),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_rdata        (rsp_rdata),
        .mem_addr         (mem_addr),
        .mem_data_in      (mem_data_in),
        .mem_write_enable (mem_write_enable),
        .mem_data_out     (mem_data_out)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_grant0      (perf_grant0),
        .perf_grant1      (perf_grant1),
        .perf_conflict    (perf_conflict)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port memory: combinational read, write on the clock edge.
    assign mem_data_out = mem_array[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_write_enable === 1'b1) mem_array[mem_addr[7:2]] <= mem_data_in;
    end

    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) we_cnt <= we_cnt + 1;
    end

    // Round-robin rule: the port after the last grant wins if it is pending.
    function automatic int rr_pick(input int last, input logic [1:0] pend);
        int pref;
        pref = 1 - last;
        if (pend[pref]) return pref;
        return last;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n      = 1'b1;
        model_last = 1;
    endtask

    task automatic run_txn(input int p, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic we, output logic [31:0] rdata, output int lat);
        int n;
        @(negedge clk);
        req_valid[p] = 1'b1;
        req_addr[p]  = addr;
        req_wdata[p] = wdata;
        req_we[p]    = we;
        #1;
        n = 0;
        while (req_ready[p] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
        model_last   = p;
        lat = 0;
        while (rsp_valid[p] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata        = rsp_rdata;
        rsp_ready[p] = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready[p] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b want 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        checks++; if (mem_data_in !== 32'h0) begin errors++; $display("FAIL reset_mem_data_in: got %h want 0", mem_data_in); end
        checks++; if (mem_write_enable !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_write_enable); end
`ifdef MEM_ARB_PERF_EN
        checks++; if (perf_grant0 !== 0 || perf_grant1 !== 0 || perf_conflict !== 0) begin
            errors++; $display("FAIL reset_perf: got %h/%h/%h want 0", perf_grant0, perf_grant1, perf_conflict);
        end
`endif
        @(negedge clk);
        rst_n      = 1'b1;
        model_last = 1;
    endtask

    task automatic test_read_idle();
        logic [31:0] rd;
        int lat;
        run_txn(0, 32'h10, 32'h0, 1'b0, rd, lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL read_latency: got %0d want 2", lat); end
        checks++; if (rd !== ref_mem[4]) begin errors++; $display("FAIL read_idle_rdata: got %h want %h", rd, ref_mem[4]); end
    endtask

    task automatic test_write_read();
        logic [31:0] rd;
        int lat;
        int we0;
        we0 = we_cnt;
        run_txn(1, 32'h20, 32'hDEADBEEF, 1'b1, rd, lat);
        ref_mem[8] = 32'hDEADBEEF;
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL write_rsp_rdata: got %h want 0", rd); end
        checks++; if (lat != 2) begin errors++; $display("FAIL write_latency: got %0d want 2", lat); end
        checks++; if (we_cnt - we0 != 1) begin errors++; $display("FAIL write_we_cycles: got %0d want 1", we_cnt - we0); end
        checks++; if (mem_write_enable !== 1'b0 || mem_addr !== 32'h20) begin
            errors++; $display("FAIL mem_hold_idle: got we=%b addr=%h want we=0 addr=20", mem_write_enable, mem_addr);
        end
        run_txn(0, 32'h20, 32'h0, 1'b0, rd, lat);
        checks++; if (rd !== ref_mem[8]) begin errors++; $display("FAIL read_after_write: got %h want %h", rd, ref_mem[8]); end
    endtask

    task automatic test_contention();
        int owner [4];
        int tcyc  [4];
        int g;
        int n;
        int exp_p;
        apply_reset();
        @(negedge clk);
        req_valid   = 2'b11;
        req_we      = 2'b00;
        req_addr[0] = 32'h00;
        req_addr[1] = 32'h08;
        rsp_ready   = 2'b11;
        g = 0;
        n = 0;
        while (g < 4 && n < 40) begin
            #1;
            if (req_ready !== 2'b00) begin
                owner[g] = int'(req_ready[1]);
                tcyc[g]  = n;
                g++;
            end
            @(negedge clk);
            n++;
        end
        req_valid = 2'b00;
        repeat (4) @(negedge clk);
        rsp_ready = 2'b00;
        checks++; if (g != 4) begin errors++; $display("FAIL contention_grants: got %0d want 4", g); end
        for (int i = 0; i < g; i++) begin
            exp_p      = rr_pick(model_last, 2'b11);
            model_last = exp_p;
            checks++; if (owner[i] != exp_p) begin errors++; $display("FAIL contention_order[%0d]: got %0d want %0d", i, owner[i], exp_p); end
            if (i > 0) begin
                checks++; if (tcyc[i] - tcyc[i-1] != 3) begin
                    errors++; $display("FAIL contention_spacing[%0d]: got %0d want 3", i, tcyc[i] - tcyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        @(negedge clk);
        req_valid   = 2'b11;
        req_we      = 2'b00;
        req_addr[0] = 32'h20;
        req_addr[1] = 32'h08;
        rsp_ready   = 2'b00;
        #1;
        checks++; if (req_ready !== (rr_pick(model_last, 2'b11) == 0 ? 2'b01 : 2'b10)) begin
            errors++; $display("FAIL bp_grant: got %b want port %0d", req_ready, rr_pick(model_last, 2'b11));
        end
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        model_last   = 0;
        @(negedge clk);
        @(negedge clk);
        held = rsp_rdata;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rsp_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, rsp_valid[0]); end
            checks++; if (rsp_rdata !== ref_mem[8]) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want %h", i, rsp_rdata, ref_mem[8]); end
            checks++; if (req_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_req_ready1[%0d]: got %b want 0", i, req_ready[1]); end
            @(negedge clk);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rsp_valid[0] !== 1'b0 || req_ready[1] !== 1'b1) begin
            errors++; $display("FAIL bp_complete: got rsp_valid0=%b req_ready1=%b want 0/1", rsp_valid[0], req_ready[1]);
        end
        checks++; if (held !== ref_mem[8]) begin errors++; $display("FAIL bp_first_rdata: got %h want %h", held, ref_mem[8]); end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h20;
        req_we[1]    = 1'b0;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 2'b10) begin errors++; $display("FAIL mid_pre_valid: got %b want 10", rsp_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL mid_rsp_valid: got %b want 00", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_write_enable !== 1'b0) begin
            errors++; $display("FAIL mid_outputs: got rdata=%h addr=%h we=%b want 0", rsp_rdata, mem_addr, mem_write_enable);
        end
        @(negedge clk);
        rst_n      = 1'b1;
        model_last = 1;
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL mid_priority: got %b want 01", req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic test_random();
        logic [1:0]  pend;
        logic [1:0]  drop;
        logic [31:0] exp_rd [2];
        int          wp;
        int          p;
        int          exp_p;
        int          done;
        int          n;
        int          granted;
        int          granted0;
        int          conflicts;
        apply_reset();
        rsp_ready = 2'b11;
        granted   = 0;
        granted0  = 0;
        conflicts = 0;
        for (int i = 0; i < 100; i++) begin
            wp = $urandom_range(0, 1);
            @(negedge clk);
            for (int q = 0; q < 2; q++) begin
                req_addr[q]  = $urandom & 32'hF8;
                req_wdata[q] = $urandom;
                req_we[q]    = (q == wp);
            end
            req_valid = 2'b11;
            pend      = 2'b11;
            drop      = 2'b00;
            done      = 0;
            n         = 0;
            while (done < 2 && n < 40) begin
                #1;
                if (req_ready !== 2'b00) begin
                    p     = int'(req_ready[1]);
                    exp_p = rr_pick(model_last, pend);
                    checks++; if (p != exp_p) begin errors++; $display("FAIL rand_grant[%0d]: got %0d want %0d", i, p, exp_p); end
                    model_last = exp_p;
                    if (pend == 2'b11) conflicts++;
                    granted++;
                    if (p == 0) granted0++;
                    pend[p] = 1'b0;
                    drop[p] = 1'b1;
                    if (req_we[p]) begin
                        ref_mem[req_addr[p][7:2]] = req_wdata[p];
                        exp_rd[p] = 32'h0;
                    end else begin
                        exp_rd[p] = ref_mem[req_addr[p][7:2]];
                    end
                end
                if (rsp_valid !== 2'b00) begin
                    p = int'(rsp_valid[1]);
                    checks++; if (rsp_rdata !== exp_rd[p]) begin
                        errors++; $display("FAIL rand_rdata[%0d] port %0d: got %h want %h", i, p, rsp_rdata, exp_rd[p]);
                    end
                    done++;
                end
                @(negedge clk);
                n++;
                for (int q = 0; q < 2; q++) begin
                    if (drop[q]) begin
                        req_valid[q] = 1'b0;
                        drop[q]      = 1'b0;
                    end
                end
            end
            if (done < 2) begin
                checks++; errors++;
                $display("FAIL rand_timeout[%0d]: got %0d responses want 2", i, done);
                i = 100;
            end
        end
        req_valid = 2'b00;
        rsp_ready = 2'b00;
`ifdef MEM_ARB_PERF_EN
        checks++; if (perf_grant0 + perf_grant1 !== 32'd200) begin
            errors++; $display("FAIL perf_total: got %0d want 200", perf_grant0 + perf_grant1);
        end
        checks++; if (perf_grant0 !== 32'(granted0)) begin errors++; $display("FAIL perf_grant0: got %0d want %0d", perf_grant0, granted0); end
        checks++; if (perf_conflict !== 32'(conflicts)) begin errors++; $display("FAIL perf_conflict: got %0d want %0d", perf_conflict, conflicts); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors     = 0;
        checks     = 0;
        we_cnt     = 0;
        model_last = 1;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_we     = '0;
        rsp_ready  = '0;
        test_reset();
        test_read_idle();
        test_write_read();
        test_contention();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
